// File: rtl/vram_blitter.sv
// vram_blitter: sprite draw / screen clear engine owning the VRAM write port.
// One command at a time. A draw fetches n sprite bytes from RAM and XORs
// cmd_plane into each set, on-screen pixel using a read-then-write pair of
// cycles, flagging CHIP-8 style collision. A clear writes 00 to all 8192 pixels.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   cmd_op                : 00 draw, 01 clear, 1x no-op
//   cmd_x/y/n/addr/plane  : sprite origin, row count, RAM address, XOR mask
//   done                  : one-cycle completion pulse
//   collision             : result of the last draw, valid from done
//   ram_addr/ram_dout     : sprite byte fetch (data one cycle after address)
//   vram_hpos/vpos        : pixel address
//   vram_pixeli/pixelo    : pixel write data / read data (one cycle latency)
//   vram_we               : pixel write enable
module vram_blitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_x,
  input  logic [5:0]  cmd_y,
  input  logic [3:0]  cmd_n,
  input  logic [11:0] cmd_addr,
  input  logic [1:0]  cmd_plane,
  output logic        done,
  output logic        collision,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [6:0]  vram_hpos,
  output logic [5:0]  vram_vpos,
  output logic [1:0]  vram_pixeli,
  input  logic [1:0]  vram_pixelo,
  output logic        vram_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_RD, S_WR, S_CLR, S_DONE
  } state_t;

  state_t      state, state_nxt;

  logic [6:0]  x_q;
  logic [5:0]  y_q;
  logic [3:0]  n_q;
  logic [11:0] addr_q;
  logic [1:0]  plane_q;
  logic [7:0]  shift_q;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [12:0] k;
  logic [11:0] ram_addr_q;
  logic [6:0]  hpos_q;
  logic [5:0]  vpos_q;

  logic        accept;
  logic [7:0]  hsum;
  logic [6:0]  vsum;
  logic        in_bounds;
  logic        active;
  logic        more_rows;
  logic [11:0] fetch_addr;

  assign accept     = cmd_valid & cmd_ready;
  // Sums are one bit wider than the screen so the right/bottom edge clips
  // instead of wrapping to column 0 / row 0.
  assign hsum       = {1'b0, x_q} + {5'b0, col};
  assign vsum       = {1'b0, y_q} + {3'b0, row};
  assign in_bounds  = ~hsum[7] & ~vsum[6];
  assign active     = shift_q[3'd7 - col] & in_bounds;
  assign more_rows  = ({1'b0, row} + 5'd1) < {1'b0, n_q};
  assign fetch_addr = addr_q + {8'b0, row};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) begin
                 case (cmd_op)
                   2'b00:   state_nxt = (cmd_n != 4'd0) ? S_FETCH : S_DONE;
                   2'b01:   state_nxt = S_CLR;
                   default: state_nxt = S_DONE;
                 endcase
               end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_RD;
      S_RD:    state_nxt = S_WR;
      S_WR:    if (col != 3'd7)  state_nxt = S_RD;
               else if (more_rows) state_nxt = S_FETCH;
               else                state_nxt = S_DONE;
      S_CLR:   if (k == 13'h1fff) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. Addresses are live in their active states and otherwise hold
  // the last value presented.
  always_comb begin
    cmd_ready   = 1'b0;
    done        = 1'b0;
    vram_we     = 1'b0;
    vram_pixeli = 2'b00;
    ram_addr    = ram_addr_q;
    vram_hpos   = hpos_q;
    vram_vpos   = vpos_q;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_FETCH: ram_addr  = fetch_addr;
      S_RD: begin
        vram_hpos = hsum[6:0];
        vram_vpos = vsum[5:0];
      end
      S_WR: begin
        vram_hpos   = hsum[6:0];
        vram_vpos   = vsum[5:0];
        vram_pixeli = vram_pixelo ^ plane_q;
        vram_we     = active;
      end
      S_CLR: begin
        vram_hpos = k[12:6];
        vram_vpos = k[5:0];
        vram_we   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      plane_q    <= '0;
      shift_q    <= '0;
      row        <= '0;
      col        <= '0;
      k          <= '0;
      collision  <= 1'b0;
      ram_addr_q <= '0;
      hpos_q     <= '0;
      vpos_q     <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        x_q       <= cmd_x;
        y_q       <= cmd_y;
        n_q       <= cmd_n;
        addr_q    <= cmd_addr;
        plane_q   <= cmd_plane;
        row       <= '0;
        col       <= '0;
        k         <= '0;
        collision <= 1'b0;
      end
      if (state == S_FETCH) ram_addr_q <= fetch_addr;
      if (state == S_LATCH) begin
        shift_q <= ram_dout;
        col     <= '0;
      end
      if (state == S_RD || state == S_WR || state == S_CLR) begin
        hpos_q <= vram_hpos;
        vpos_q <= vram_vpos;
      end
      if (state == S_WR) begin
        if (active && (vram_pixelo & plane_q) != 2'b00) collision <= 1'b1;
        if (col != 3'd7) col <= col + 3'd1;
        else if (more_rows) row <= row + 4'd1;
      end
      if (state == S_CLR) k <= k + 13'd1;
    end
  end

endmodule

// File: tb/tb_vram_blitter.sv
// Bench for vram_blitter: a hand-written vector table for the documented
// scenarios, randomized draws checked against a pixel-level reference model,
// and a reset-abort sequence. The bench owns RAM and VRAM behavioural models.
module tb_vram_blitter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic [3:0]  cmd_n;
  logic [11:0] cmd_addr;
  logic [1:0]  cmd_plane;
  logic        done;
  logic        collision;
  logic [11:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [6:0]  vram_hpos;
  logic [5:0]  vram_vpos;
  logic [1:0]  vram_pixeli;
  logic [1:0]  vram_pixelo;
  logic        vram_we;

  vram_blitter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n),
    .cmd_addr(cmd_addr), .cmd_plane(cmd_plane), .done(done),
    .collision(collision), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixeli(vram_pixeli),
    .vram_pixelo(vram_pixelo), .vram_we(vram_we)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [4096];
  logic [1:0] mem [128][64];   // physical VRAM written by the DUT
  logic [1:0] mdl [128][64];   // expected VRAM contents
  int         hits [128][64];
  int         wcount, nzw;
  bit         saw_fetch;
  logic [11:0] watch_addr;

  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    ram_dout    <= ram[ram_addr];
    vram_pixelo <= mem[vram_hpos][vram_vpos];
    if (ram_addr == watch_addr) saw_fetch = 1'b1;
    if (vram_we) begin
      mem[vram_hpos][vram_vpos] <= vram_pixeli;
      wcount = wcount + 1;
      hits[vram_hpos][vram_vpos] = hits[vram_hpos][vram_vpos] + 1;
      if (vram_pixeli != 2'b00) nzw = nzw + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: walk the sprite rows/columns and apply the XOR/clip rules.
  task automatic model_cmd(input logic [1:0] op, input int x, input int y, input int n,
                           input int addr, input logic [1:0] plane,
                           output int lat, output bit col, output int wc);
    col = 0; wc = 0;
    if (op == 2'b01) begin
      for (int h = 0; h < 128; h++) for (int v = 0; v < 64; v++) mdl[h][v] = 2'b00;
      wc = 8192; lat = 8193;
    end else if (op == 2'b00 && n != 0) begin
      for (int r = 0; r < n; r++) begin
        logic [7:0] b;
        b = ram[(addr + r) % 4096];
        for (int c = 0; c < 8; c++)
          if (b[7-c] && x + c < 128 && y + r < 64) begin
            if ((mdl[x+c][y+r] & plane) != 2'b00) col = 1;
            mdl[x+c][y+r] = mdl[x+c][y+r] ^ plane;
            wc++;
          end
      end
      lat = 18 * n + 1;
    end else lat = 1;
  endtask

  task automatic vram_cmp(input string name);
    int bad = 0;
    for (int h = 0; h < 128; h++)
      for (int v = 0; v < 64; v++)
        if (mem[h][v] !== mdl[h][v]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [6:0] x,
                         input logic [5:0] y, input logic [3:0] n, input logic [11:0] addr,
                         input logic [1:0] plane, input int elat, input bit ecol,
                         input int ewc, input bit vchk);
    int got = -1;
    int waitc = 0;
    @(negedge clk);
    while (!cmd_ready && waitc < 20) begin @(negedge clk); waitc++; end
    chk({name, " ready_before"}, cmd_ready, 1);
    wcount = 0; nzw = 0;
    if (op == 2'b01)
      for (int h = 0; h < 128; h++) for (int v = 0; v < 64; v++) hits[h][v] = 0;
    cmd_valid = 1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_n = n;
    cmd_addr = addr; cmd_plane = plane;
    @(posedge clk);
    #1 cmd_valid = 0;
    for (int cyc = 1; cyc <= 9000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({name, " col_cleared"}, collision, 0);
        if (elat > 1) chk({name, " busy"}, cmd_ready, 0);
      end
      if (done) begin got = cyc; break; end
    end
    chk({name, " latency"}, got, elat);
    chk({name, " collision"}, collision, ecol);
    chk({name, " writes"}, wcount, ewc);
    @(negedge clk);
    chk({name, " done_pulse"}, done, 0);
    chk({name, " ready_after"}, cmd_ready, 1);
    if (op == 2'b01) begin
      int badh = 0;
      for (int h = 0; h < 128; h++) for (int v = 0; v < 64; v++) if (hits[h][v] != 1) badh++;
      chk({name, " clr_cover"}, badh, 0);
      chk({name, " clr_data"}, nzw, 0);
    end
    if (vchk) vram_cmp({name, " vram"});
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [3:0]  n;
    logic [11:0] addr;
    logic [1:0]  plane;
    logic [7:0]  b0, b1;
    int          lat;
    bit          col;
    int          wc;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, wc;
    bit col;
    watch_addr = 12'hfff;
    reset = 1; cmd_valid = 1; cmd_op = 0; cmd_x = 0; cmd_y = 0; cmd_n = 1;
    cmd_addr = 0; cmd_plane = 1; wcount = 0; nzw = 0; saw_fetch = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int h = 0; h < 128; h++)
      for (int v = 0; v < 64; v++) begin mem[h][v] = 0; mdl[h][v] = 0; hits[h][v] = 0; end

    // Reset with a pending request: nothing may be accepted or written.
    repeat (4) @(negedge clk);
    chk("rst ready", cmd_ready, 1);
    chk("rst done", done, 0);
    chk("rst we", vram_we, 0);
    chk("rst collision", collision, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst hpos", vram_hpos, 0);
    chk("rst vpos", vram_vpos, 0);
    chk("rst no writes", wcount, 0);
    cmd_valid = 0;
    @(negedge clk); reset = 0;

    //        op x    y  n  addr     pl  b0     b1     lat   col wc
    vecs[0] = '{2'd0, 7'd0,   6'd0,  4'd1, 12'h100, 2'd1, 8'hf0, 8'h00, 19,   0, 4};
    vecs[1] = '{2'd0, 7'd0,   6'd0,  4'd1, 12'h100, 2'd1, 8'hf0, 8'h00, 19,   1, 4};
    vecs[2] = '{2'd0, 7'd124, 6'd63, 4'd2, 12'hfff, 2'd3, 8'hff, 8'hff, 37,   0, 4};
    vecs[3] = '{2'd0, 7'd5,   6'd5,  4'd0, 12'h300, 2'd1, 8'hff, 8'hff, 1,    0, 0};
    vecs[4] = '{2'd2, 7'd5,   6'd5,  4'd5, 12'h300, 2'd1, 8'hff, 8'hff, 1,    0, 0};
    vecs[5] = '{2'd3, 7'd9,   6'd9,  4'd9, 12'h300, 2'd3, 8'hff, 8'hff, 1,    0, 0};
    vecs[6] = '{2'd1, 7'd0,   6'd0,  4'd0, 12'h000, 2'd0, 8'h00, 8'h00, 8193, 0, 8192};

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].op == 2'd0 && vecs[i].n != 0) begin
        ram[vecs[i].addr] = vecs[i].b0;
        ram[(int'(vecs[i].addr) + 1) % 4096] = vecs[i].b1;
      end
      model_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].n, vecs[i].addr,
                vecs[i].plane, lat, col, wc);
      if (vecs[i].op == 2'd0 && vecs[i].x == 7'd124) begin
        chk("clip pix0", {30'd0, mem[0][63]}, 0);
        chk("clip vpos0", {30'd0, mem[124][0]}, 0);
      end
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].n,
              vecs[i].addr, vecs[i].plane, vecs[i].lat, vecs[i].col, vecs[i].wc, 1);
      if (i == 1) chk("vec1 pix erased", {30'd0, mem[2][0]}, 0);
      if (i == 2) begin
        chk("clip wrap col0", {30'd0, mem[0][63]}, 0);
        chk("clip edge", {30'd0, mem[127][63]}, 3);
      end
    end

    // Randomized draws against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op;
      logic [6:0] x; logic [5:0] y; logic [3:0] n; logic [11:0] a; logic [1:0] pl;
      op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'd0;
      x = 7'($urandom); y = 6'($urandom); n = 4'($urandom);
      a = 12'($urandom); pl = 2'($urandom);
      model_cmd(op, x, y, n, a, pl, lat, col, wc);
      run_cmd($sformatf("rnd%0d", t), op, x, y, n, a, pl, lat, col, wc, 1);
    end

    // Abort: reset during a row-1 write of an n=3 draw.
    for (int i = 0; i < 3; i++) ram[12'h200 + i] = 8'hff;
    @(negedge clk);
    cmd_valid = 1; cmd_op = 0; cmd_x = 10; cmd_y = 10; cmd_n = 3;
    cmd_addr = 12'h200; cmd_plane = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (26) @(negedge clk);
    chk("abort we_before", vram_we, 1);
    watch_addr = 12'h202; saw_fetch = 0;
    reset = 1;
    #1 chk("abort we_async", vram_we, 0);
    repeat (2) @(negedge clk);
    reset = 0; wcount = 0;
    #1 chk("abort ready", cmd_ready, 1);
    repeat (30) @(negedge clk);
    chk("abort no row2", saw_fetch, 0);
    chk("abort no writes", wcount, 0);
    chk("abort ram_addr", ram_addr, 0);
    watch_addr = 12'hfff;
    run_cmd("abort n0", 2'd0, 7'd3, 6'd3, 4'd0, 12'h000, 2'd1, 1, 0, 0, 0);
    model_cmd(2'd1, 0, 0, 0, 0, 2'd0, lat, col, wc);
    run_cmd("final clr", 2'd1, 7'd0, 6'd0, 4'd0, 12'h000, 2'd0, lat, col, wc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
